// File: rtl/fifo_wr_arbiter.sv
// Round-robin N:1 FIFO write arbiter with a one-entry registered output stage; accepted beat shows on wren/wdata after 1 cycle.
// wfull holds the output register and withdraws req_ready; burst lock is compiled in with FIFO_WR_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wren,
  output logic [DATA_W-1:0]           wdata,
  input  logic                        wfull,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        grant_valid,
  output logic [15:0]                 wr_count
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_nxt;
  logic [IDW-1:0]    rr_id;
  logic              loadable;
  logic              accept;
  logic              commit;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    rr_id = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        rr_id = IDW'(idx);
        found = 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARB_BURST_EN
  typedef enum logic {ARB, LOCK} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] lock_id_nxt;
  logic [7:0]     beat_cnt;
  logic [7:0]     beat_cnt_nxt;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= ARB;
      lock_id  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_id  <= lock_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_id_nxt  = lock_id;
    beat_cnt_nxt = beat_cnt;
    ptr_nxt      = ptr;
    case (state)
      ARB: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            ptr_nxt = inc_id(grant_id);
          end else begin
            state_nxt    = LOCK;
            lock_id_nxt  = grant_id;
            beat_cnt_nxt = 8'd1;
          end
        end
      end
      LOCK: begin
        if (!req_valid[lock_id]) begin
          state_nxt    = ARB;
          ptr_nxt      = inc_id(lock_id);
          beat_cnt_nxt = '0;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          if (beat_cnt_nxt == 8'(MAX_BURST)) begin
            state_nxt    = ARB;
            ptr_nxt      = inc_id(lock_id);
            beat_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    grant_id    = (state == LOCK) ? lock_id : rr_id;
    grant_valid = !wrst && ((|req_valid) || (state == LOCK));
  end
`else
  always_comb begin
    ptr_nxt = accept ? inc_id(grant_id) : ptr;
  end

  always_comb begin
    grant_id    = rr_id;
    grant_valid = !wrst && (|req_valid);
  end
`endif

  assign loadable = !wren || !wfull;
  assign commit   = wren && !wfull;

  always_comb begin
    req_ready = '0;
    if (grant_valid && loadable && req_valid[grant_id]) req_ready[grant_id] = 1'b1;
  end

  assign accept = |req_ready;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // A held beat is dropped on reset; it never reaches the FIFO.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      ptr      <= '0;
      wren     <= 1'b0;
      wdata    <= '0;
      wr_count <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (accept) begin
        wren  <= 1'b1;
        wdata <= sel_data;
      end else if (commit) begin
        wren <= 1'b0;
      end
      if (commit && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- NUM_REQ, 4: number of write requesters (2..8).
- DATA_W, 32: FIFO write data width.
- MAX_BURST, 8: beat limit per grant when burst lock is compiled in (1..255).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- wclk, in, 1: sole clock, rising edge.
- wrst, in, 1: synchronous active-high reset.
- req_valid, in, NUM_REQ: per-requester beat valid.
- req_data, in, NUM_REQ*DATA_W: requester i data in bits [i*DATA_W +: DATA_W].
- req_ready, out, NUM_REQ: per-requester beat accepted this cycle.
- wren, out, 1: FIFO write enable, registered.
- wdata, out, DATA_W: FIFO write data, registered.
- wfull, in, 1: FIFO full flag, write-clock domain.
- grant_id, out, $clog2(NUM_REQ): index of the currently granted requester.
- grant_valid, out, 1: grant_id is meaningful.
- wr_count, out, 16: committed FIFO writes, saturating.
REQ-003 The block SHALL use one clock and synchronous active-high reset: wclk and wrst.

Function
REQ-004 Output stage SHALL be a one-entry register (wren = occupied, wdata = held data); a FIFO write commits on any cycle with wren=1 and wfull=0.
REQ-005 The output register SHALL be loadable when wren=0 or wfull=0.
REQ-006 req_ready[i] SHALL be 1 only when i == grant_id, grant_valid=1, req_valid[i]=1 and the output register is loadable; at most one bit is set per cycle.
REQ-007 A beat SHALL be accepted when req_valid[i] and req_ready[i] are both 1. It appears on wdata/wren at the next edge, giving 1-cycle latency.
REQ-008 If no beat is accepted and the held beat commits, wren SHALL clear at the next edge. If wfull=1, wren and wdata SHALL hold unchanged.
REQ-009 Arbitration SHALL be round-robin using a priority pointer ptr. grant_id is the first index at or after ptr (modulo NUM_REQ) with req_valid set.
REQ-010 grant_valid SHALL be 1 when any req_valid bit is 1 or a lock is active.
REQ-011 In state ARB, each accepted beat from requester i SHALL set ptr to (i+1) mod NUM_REQ.
REQ-012 With no accepted beat, ptr SHALL be unchanged. wfull stalls SHALL NOT move ptr.
REQ-013 wr_count SHALL increment on each commit (REQ-004) and saturate at 16'hFFFF.
REQ-014 req_valid deasserting while wfull=1 SHALL NOT corrupt or drop the held beat.
REQ-015 States SHALL be ARB and LOCK. LOCK is reachable only per REQ-020.

Reset
REQ-016 While wrst=1 at a rising edge, the following SHALL result: wren=0, wdata=0, ptr=0, state=ARB, beat counter=0, wr_count=0.
REQ-017 During reset, req_ready SHALL be all zero and grant_valid=0.
REQ-018 Reset mid-operation SHALL discard any held beat; it is never written.
REQ-019 The first cycle after reset SHALL grant the lowest active index starting from 0.

Configuration
REQ-020 With macro FIFO_WR_ARB_BURST_EN defined, burst lock SHALL operate as follows:
- Accepting a beat in ARB enters LOCK on requester i with beat count 1, and ptr is not advanced.
- In LOCK, grant_id stays i while req_valid[i]=1, regardless of other requesters.
- Each accepted beat increments the beat count.
- LOCK returns to ARB and sets ptr=(i+1) mod NUM_REQ when req_valid[i]=0 or the count reaches MAX_BURST on an accept.
REQ-021 Without FIFO_WR_ARB_BURST_EN, the state SHALL remain ARB, no beat counter SHALL be synthesized, and behaviour is per-beat round-robin only.

Verification
REQ-022 Reset, all req_valid=1, wfull=0 (no burst macro) -> grants 0,1,2,3,0 on consecutive cycles; wren=1 from cycle 2; wr_count=5 after 6 cycles.
REQ-023 Single requester 2, data 32'hA5A5_0001, wfull=0 -> wdata=32'hA5A5_0001 with wren=1 exactly one cycle after the accept.
REQ-024 wren=1 holding 32'hDEAD_BEEF, wfull=1 for 5 cycles -> wdata stable; req_ready=0; ptr unchanged; wr_count unchanged; commit on the first cycle wfull=0.
REQ-025 Burst macro on, MAX_BURST=3, req 0 and req 1 continuously valid -> grant sequence 0,0,0,1,1,1,0.
REQ-026 wrst asserted while wren=1 with data 32'h1234_5678 -> next cycle wren=0; wr_count=0; that data never committed.
REQ-027 wr_count preloaded near saturation via 65540 commits -> wr_count holds 16'hFFFF.
